// File: rtl/st7785_init_sequencer.sv
// st7785_init_sequencer
// Power-up and sleep/wake command sequencer for the ST7785 panel. It drives the
// panel hardware reset and the 3-wire 9-bit SPI command port. It runs a fixed
// command ROM, with millisecond delays, for either the init or the sleep sequence.
//
// Optional feature macro: ST7785_INVON_EN adds 21h (display inversion on) to the
// init ROM, placed just before 29h.
//
// Ports:
//   gClk        system clock
//   gRst        asynchronous active-high reset
//   start       pulse: hardware reset plus init sequence (ignored while busy)
//   sleep_req   pulse: sleep sequence (from READY; latched while init runs)
//   panel_ready panel initialised and awake; gates LCD_EN of the scanout block
//   busy        a sequence is running
//   done        one-cycle pulse when a sequence completes
//   LCD_RESETn  panel hardware reset, active low
//   LCD_CS      SPI chip select, active low
//   LCD_SCL     SPI clock, idles low
//   LCD_SDA     SPI data: D/C bit first, then D7..D0
//
// RESET_WAIT_CYC must be >= 2. The LOAD cycle before the first byte is counted
// as part of that wait.
module st7785_init_sequencer #(
  parameter int unsigned CLK_DIV        = 4,
  parameter int unsigned MS_CYC         = 24000,
  parameter int unsigned RESET_LOW_CYC  = 240,
  parameter int unsigned RESET_WAIT_CYC = 2880000
) (
  input  logic gClk,
  input  logic gRst,
  input  logic start,
  input  logic sleep_req,
  output logic panel_ready,
  output logic busy,
  output logic done,
  output logic LCD_RESETn,
  output logic LCD_CS,
  output logic LCD_SCL,
  output logic LCD_SDA
);

`ifdef ST7785_INVON_EN
  localparam logic [2:0] INIT_LEN = 3'd6;
`else
  localparam logic [2:0] INIT_LEN = 3'd5;
`endif
  localparam logic [2:0]  INIT_LAST     = INIT_LEN - 3'd1;
  localparam logic [2:0]  SLEEP_LAST    = INIT_LEN + 3'd1;
  localparam logic [23:0] RST_LOW_LAST  = 24'(RESET_LOW_CYC - 1);
  localparam logic [23:0] RST_WAIT_LAST = 24'(RESET_WAIT_CYC - 2);
  localparam logic [23:0] GAP_LAST      = 24'(CLK_DIV - 1);
  localparam logic [15:0] SCL_HIGH      = 16'(CLK_DIV);
  localparam logic [15:0] BIT_LAST      = 16'(2 * CLK_DIV - 1);
  localparam logic [19:0] TICK_LAST     = 20'(MS_CYC - 1);

  typedef enum logic [3:0] {
    StIdle, StRstLow, StRstWait, StLoad, StShift, StGap, StDelay, StReady, StAsleep
  } stateT;

  stateT       stateQ, stateD, endState;
  logic [2:0]  idxQ;        // ROM index: init entries first, then sleep entries
  logic [1:0]  parQ;        // params already sent for the current entry
  logic [23:0] cntQ;        // cycles spent in the current state
  logic [15:0] phaseQ;
  logic [3:0]  bitQ;
  logic [8:0]  shiftQ;
  logic [19:0] tickQ;
  logic [7:0]  msQ;
  logic        rstRelQ, sleepPendQ, doneQ;

  logic [7:0]  romCmd, romP0, romP1, romDly;
  logic [1:0]  romNpar;
  logic        isInit, lastEntry, moreParams, bitEnd, shiftEnd, gapEnd, delayEnd;

  // Command ROM
  always_comb begin
    romCmd  = 8'h00;
    romNpar = 2'd0;
    romP0   = 8'h00;
    romP1   = 8'h00;
    romDly  = 8'd0;
    if (idxQ == INIT_LAST) begin
      romCmd = 8'h29;
      romDly = 8'd20;
    end else if (idxQ == INIT_LEN) begin
      romCmd = 8'h28;
    end else if (idxQ == SLEEP_LAST) begin
      romCmd = 8'h10;
      romDly = 8'd5;
    end else begin
      case (idxQ)
        3'd0: begin romCmd = 8'h11; romDly = 8'd120; end
        3'd1: begin romCmd = 8'h3A; romNpar = 2'd1; romP0 = 8'h66; end
        3'd2: begin romCmd = 8'h36; romNpar = 2'd1; romP0 = 8'h00; end
        3'd3: begin romCmd = 8'hB0; romNpar = 2'd2; romP0 = 8'h11; romP1 = 8'hC0; end
`ifdef ST7785_INVON_EN
        3'd4: romCmd = 8'h21;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    isInit     = idxQ < INIT_LEN;
    lastEntry  = (idxQ == INIT_LAST) || (idxQ == SLEEP_LAST);
    moreParams = parQ < romNpar;
    bitEnd     = phaseQ == BIT_LAST;
    shiftEnd   = bitEnd && (bitQ == 4'd8);
    gapEnd     = cntQ == GAP_LAST;
    delayEnd   = (tickQ == TICK_LAST) && (msQ == romDly - 8'd1);
    // A sleep request during init chains straight into the sleep entries.
    if (isInit && (sleepPendQ || sleep_req)) endState = StLoad;
    else if (isInit)                         endState = StReady;
    else                                     endState = StAsleep;
  end

  // State register
  always_ff @(posedge gClk or posedge gRst) begin
    if (gRst) stateQ <= StIdle;
    else      stateQ <= stateD;
  end

  // Next state
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle, StAsleep: if (start) stateD = StRstLow;
      StReady: begin
        if (start)          stateD = StRstLow;
        else if (sleep_req) stateD = StLoad;
      end
      StRstLow:  if (cntQ == RST_LOW_LAST) stateD = StRstWait;
      StRstWait: if (cntQ == RST_WAIT_LAST) stateD = StLoad;
      StLoad:    stateD = StShift;
      StShift:   if (shiftEnd) stateD = StGap;
      StGap: begin
        if (gapEnd) begin
          if (moreParams)           stateD = StShift;
          else if (romDly != 8'd0)  stateD = StDelay;
          else if (lastEntry)       stateD = endState;
          else                      stateD = StLoad;
        end
      end
      StDelay:   if (delayEnd) stateD = lastEntry ? endState : StLoad;
      default:   stateD = StIdle;
    endcase
  end

  // Datapath
  always_ff @(posedge gClk or posedge gRst) begin
    if (gRst) begin
      idxQ       <= '0;
      parQ       <= '0;
      cntQ       <= '0;
      phaseQ     <= '0;
      bitQ       <= '0;
      shiftQ     <= '0;
      tickQ      <= '0;
      msQ        <= '0;
      rstRelQ    <= 1'b0;
      sleepPendQ <= 1'b0;
      doneQ      <= 1'b0;
    end else begin
      if (stateD != stateQ) cntQ <= '0;
      else if (cntQ != '1) cntQ <= cntQ + 24'd1;

      if (stateD == StRstLow)      rstRelQ <= 1'b0;
      else if (stateQ == StRstLow) rstRelQ <= 1'b1;

      if (stateD == StRstLow) idxQ <= '0;
      else if (stateD == StLoad && stateQ == StReady) idxQ <= INIT_LEN;
      else if (stateD == StLoad && (stateQ == StGap || stateQ == StDelay)) idxQ <= idxQ + 3'd1;

      if (stateD == StRstLow || stateD == StReady || (stateD == StLoad && idxQ == INIT_LAST))
        sleepPendQ <= 1'b0;
      else if (busy && isInit && sleep_req)
        sleepPendQ <= 1'b1;

      doneQ <= busy && (stateD == StReady || stateD == StAsleep);

      if (stateQ == StLoad) begin
        shiftQ <= {1'b0, romCmd};
        phaseQ <= '0;
        bitQ   <= '0;
        parQ   <= '0;
      end else if (stateQ == StGap && stateD == StShift) begin
        shiftQ <= {1'b1, (parQ == 2'd0) ? romP0 : romP1};
        phaseQ <= '0;
        bitQ   <= '0;
        parQ   <= parQ + 2'd1;
      end else if (stateQ == StShift) begin
        if (bitEnd) begin
          // Next bit appears at the start of the SCL-low phase
          phaseQ <= '0;
          shiftQ <= {shiftQ[7:0], 1'b0};
          if (bitQ != 4'd8) bitQ <= bitQ + 4'd1;
        end else begin
          phaseQ <= phaseQ + 16'd1;
        end
      end

      if (stateQ != StDelay) begin
        tickQ <= '0;
        msQ   <= '0;
      end else if (tickQ == TICK_LAST) begin
        tickQ <= '0;
        if (msQ != 8'hFF) msQ <= msQ + 8'd1;
      end else begin
        tickQ <= tickQ + 20'd1;
      end
    end
  end

  // Outputs
  always_comb begin
    busy        = !(stateQ inside {StIdle, StReady, StAsleep});
    // Pixels are withdrawn in the same cycle as the sleep request.
    panel_ready = (stateQ == StReady) && !sleep_req;
    done        = doneQ;
    LCD_RESETn  = rstRelQ;
    LCD_CS      = stateQ != StShift;
    LCD_SCL     = (stateQ == StShift) && (phaseQ >= SCL_HIGH);
    LCD_SDA     = shiftQ[8];
  end

endmodule

// File: tb/tb_st7785_init_sequencer.sv
// Bench for st7785_init_sequencer: it decodes the SPI bus and compares the result
// against a command list built from the panel ROM tables.
module tb_st7785_init_sequencer;
  localparam int CLK_DIV        = 2;
  localparam int MS_CYC         = 10;
  localparam int RESET_LOW_CYC  = 5;
  localparam int RESET_WAIT_CYC = 10;

  logic gClk = 1'b0;
  logic gRst = 1'b1;
  logic start = 1'b0;
  logic sleep_req = 1'b0;
  logic panel_ready, busy, done, LCD_RESETn, LCD_CS, LCD_SCL, LCD_SDA;

  st7785_init_sequencer #(
    .CLK_DIV(CLK_DIV),
    .MS_CYC(MS_CYC),
    .RESET_LOW_CYC(RESET_LOW_CYC),
    .RESET_WAIT_CYC(RESET_WAIT_CYC)
  ) dut (
    .gClk(gClk),
    .gRst(gRst),
    .start(start),
    .sleep_req(sleep_req),
    .panel_ready(panel_ready),
    .busy(busy),
    .done(done),
    .LCD_RESETn(LCD_RESETn),
    .LCD_CS(LCD_CS),
    .LCD_SCL(LCD_SCL),
    .LCD_SDA(LCD_SDA)
  );

  always #5 gClk = ~gClk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // SPI monitor
  int cyc = 0;
  always @(posedge gClk) cyc++;

  logic [8:0] gotByte[$];
  int gotGap[$], gotLen[$], gotBits[$];
  bit inByte = 0;
  logic [8:0] shReg;
  int nBits, lowLen, curGap;
  int highCnt = 0;
  int lastRiseCyc = 0, readyCyc = 0, doneCyc = 0;
  int readyRises = 0, doneCnt = 0, sdaViol = 0;
  logic prevScl = 0, prevSda = 0, prevReady = 0;

  always @(negedge gClk) begin
    if (gRst) begin
      inByte  = 0;
      highCnt = 0;
    end else begin
      if (!LCD_RESETn) begin
        highCnt = 0;
      end else if (LCD_CS) begin
        if (inByte) begin
          gotByte.push_back(shReg);
          gotGap.push_back(curGap);
          gotLen.push_back(lowLen);
          gotBits.push_back(nBits);
          inByte      = 0;
          lastRiseCyc = cyc;
          highCnt     = 1;
        end else begin
          highCnt++;
        end
      end else begin
        if (!inByte) begin
          inByte = 1;
          shReg  = '0;
          nBits  = 0;
          lowLen = 0;
          curGap = highCnt;
        end
        lowLen++;
        if (LCD_SCL && !prevScl) begin
          shReg = {shReg[7:0], LCD_SDA};
          nBits++;
        end
        if (LCD_SCL && prevScl && (LCD_SDA != prevSda)) sdaViol++;
      end
      if (panel_ready && !prevReady) begin
        readyRises++;
        readyCyc = cyc;
      end
      if (done) begin
        doneCnt++;
        doneCyc = cyc;
      end
    end
    prevScl   = LCD_SCL;
    prevSda   = LCD_SDA;
    prevReady = panel_ready;
  end

  // Reference model: expected byte stream with the CS-high gap before each byte
  logic [8:0] expByte[$];
  int expGap[$];
  int nextGap;

  task automatic addEntry(input logic [7:0] cmd, input int np, input logic [7:0] p0,
                          input logic [7:0] p1, input int dlyMs);
    expByte.push_back({1'b0, cmd});
    expGap.push_back(nextGap);
    if (np > 0) begin
      expByte.push_back({1'b1, p0});
      expGap.push_back(CLK_DIV);
    end
    if (np > 1) begin
      expByte.push_back({1'b1, p1});
      expGap.push_back(CLK_DIV);
    end
    // GAP, then the delay, then one LOAD cycle fetching the next entry
    nextGap = CLK_DIV + dlyMs * MS_CYC + 1;
  endtask

  task automatic buildInit();
    nextGap = RESET_WAIT_CYC;
    addEntry(8'h11, 0, 8'h00, 8'h00, 120);
    addEntry(8'h3A, 1, 8'h66, 8'h00, 0);
    addEntry(8'h36, 1, 8'h00, 8'h00, 0);
    addEntry(8'hB0, 2, 8'h11, 8'hC0, 0);
`ifdef ST7785_INVON_EN
    addEntry(8'h21, 0, 8'h00, 8'h00, 0);
`endif
    addEntry(8'h29, 0, 8'h00, 8'h00, 20);
  endtask

  task automatic buildSleep();
    addEntry(8'h28, 0, 8'h00, 8'h00, 0);
    addEntry(8'h10, 0, 8'h00, 8'h00, 5);
  endtask

  task automatic clearAll();
    gotByte.delete();
    gotGap.delete();
    gotLen.delete();
    gotBits.delete();
    expByte.delete();
    expGap.delete();
    readyRises = 0;
    doneCnt    = 0;
    sdaViol    = 0;
  endtask

  task automatic checkBytes(input string run);
    check({run, "_nbytes"}, gotByte.size(), expByte.size());
    for (int i = 0; i < expByte.size() && i < gotByte.size(); i++) begin
      check($sformatf("%s_byte%0d", run, i), gotByte[i], expByte[i]);
      check($sformatf("%s_bits%0d", run, i), gotBits[i], 9);
      check($sformatf("%s_cslow%0d", run, i), gotLen[i], 18 * CLK_DIV);
      if (expGap[i] >= 0) check($sformatf("%s_gap%0d", run, i), gotGap[i], expGap[i]);
    end
    check({run, "_sda_stable"}, sdaViol, 0);
  endtask

  task automatic pulseStart();
    @(posedge gClk); #1 start = 1'b1;
    @(posedge gClk); #1 start = 1'b0;
  endtask

  task automatic pulseSleep();
    @(posedge gClk); #1 sleep_req = 1'b1;
    @(posedge gClk); #1 sleep_req = 1'b0;
  endtask

  task automatic waitDone(input int maxCyc, output bit ok);
    ok = 0;
    for (int i = 0; i < maxCyc; i++) begin
      if (done) begin
        ok = 1;
        break;
      end
      @(posedge gClk); #1;
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge gClk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit ok;

    // Reset held, with start pulsed: nothing may happen
    waitCycles(2);
    start = 1'b1;
    waitCycles(1);
    start = 1'b0;
    waitCycles(3);
    check("rst_resetn", LCD_RESETn, 0);
    check("rst_cs", LCD_CS, 1);
    check("rst_scl", LCD_SCL, 0);
    check("rst_sda", LCD_SDA, 0);
    check("rst_ready", panel_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nbytes", gotByte.size(), 0);
    gRst = 1'b0;

    // Init from IDLE, with a stray start while busy
    clearAll();
    buildInit();
    waitCycles($urandom_range(1, 20));
    pulseStart();
    check("init_busy_c1", busy, 1);
    check("init_resetn_c1", LCD_RESETn, 0);
    n = 0;
    while (LCD_RESETn == 1'b0 && n < 100) begin
      n++;
      waitCycles(1);
    end
    check("init_resetn_low", n, RESET_LOW_CYC);
    waitCycles($urandom_range(1, 300));
    pulseStart();
    waitDone(5000, ok);
    check("init_timeout", ok, 1);
    waitCycles(3);
    checkBytes("init");
    check("init_ready", panel_ready, 1);
    check("init_busy_end", busy, 0);
    check("init_done_cnt", doneCnt, 1);
    check("init_ready_lat", readyCyc - lastRiseCyc, CLK_DIV + 20 * MS_CYC);
    check("init_done_cyc", doneCyc, readyCyc);

    // Sleep from READY
    clearAll();
    nextGap = -1;
    buildSleep();
    waitCycles($urandom_range(1, 30));
    pulseSleep();
    check("slp_ready_drop", panel_ready, 0);
    check("slp_busy", busy, 1);
    waitDone(2000, ok);
    check("slp_timeout", ok, 1);
    waitCycles(3);
    checkBytes("slp");
    check("slp_done_cnt", doneCnt, 1);
    check("slp_done_lat", doneCyc - lastRiseCyc, CLK_DIV + 5 * MS_CYC);
    check("slp_ready_rises", readyRises, 0);
    check("slp_ready", panel_ready, 0);
    check("slp_busy_end", busy, 0);

    // A second sleep request in ASLEEP is ignored
    clearAll();
    pulseSleep();
    waitCycles(100);
    check("slp2_nbytes", gotByte.size(), 0);
    check("slp2_busy", busy, 0);
    check("slp2_done_cnt", doneCnt, 0);
    check("slp2_resetn", LCD_RESETn, 1);

    // Start from ASLEEP, sleep request lands inside the 120 ms delay
    clearAll();
    buildInit();
    buildSleep();
    pulseStart();
    n = 0;
    while (gotByte.size() < 1 && n < 200) begin
      n++;
      waitCycles(1);
    end
    check("chain_first_byte", gotByte.size(), 1);
    waitCycles($urandom_range(5, 1100));
    pulseSleep();
    waitDone(5000, ok);
    check("chain_timeout", ok, 1);
    waitCycles(3);
    checkBytes("chain");
    check("chain_done_cnt", doneCnt, 1);
    check("chain_ready_rises", readyRises, 0);
    check("chain_ready", panel_ready, 0);
    check("chain_busy_end", busy, 0);
    check("chain_done_lat", doneCyc - lastRiseCyc, CLK_DIV + 5 * MS_CYC);

    // Reset in the middle of a byte
    clearAll();
    pulseStart();
    n = 0;
    while (LCD_CS == 1'b1 && n < 200) begin
      n++;
      waitCycles(1);
    end
    waitCycles($urandom_range(0, 30));
    check("mid_cs_low", LCD_CS, 0);
    @(negedge gClk);
    #2 gRst = 1'b1;
    #1;
    check("mid_cs", LCD_CS, 1);
    check("mid_scl", LCD_SCL, 0);
    check("mid_resetn", LCD_RESETn, 0);
    check("mid_busy", busy, 0);
    waitCycles(2);
    gRst = 1'b0;

    // Full rerun after the mid-byte reset
    clearAll();
    buildInit();
    waitCycles($urandom_range(1, 10));
    pulseStart();
    n = 0;
    while (LCD_RESETn == 1'b0 && n < 100) begin
      n++;
      waitCycles(1);
    end
    check("rerun_resetn_low", n, RESET_LOW_CYC);
    waitDone(5000, ok);
    check("rerun_timeout", ok, 1);
    waitCycles(3);
    checkBytes("rerun");
    check("rerun_ready", panel_ready, 1);
    check("rerun_done_cnt", doneCnt, 1);
    check("rerun_ready_lat", readyCyc - lastRiseCyc, CLK_DIV + 20 * MS_CYC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/st7785_init_sequencer.md
# st7785_init_sequencer

Power-up and sleep/wake command sequencer for the ST7785 panel. Drives the panel hardware reset and the 3-wire 9-bit SPI command port, running a fixed ROM of initialisation or sleep commands with millisecond delays. `panel_ready` gates `LCD_EN` of the RGB scanout block: pixels are released only after DISPON has settled, and are withdrawn before DISPOFF/SLPIN. Lives in the gClk domain next to the panel master.

## Interface
Parameters:
- CLK_DIV, 4: gClk cycles per SCL half-period (≥1)
- MS_CYC, 24000: gClk cycles per millisecond (20-bit)
- RESET_LOW_CYC, 240: LCD_RESETn low time in gClk cycles (20-bit)
- RESET_WAIT_CYC, 2880000: wait after reset release before the first byte (24-bit)

Ports (one clock; reset is asynchronous and active-high):
- gClk  in  1  system clock
- gRst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse: run hardware reset plus the init sequence
- sleep_req  in  1  one-cycle pulse: run the sleep sequence
- panel_ready  out  1  high when the panel is initialised and awake; drives LCD_EN
- busy  out  1  high while any sequence is running
- done  out  1  one-cycle pulse when a sequence completes
- LCD_RESETn  out  1  panel hardware reset, active low
- LCD_CS  out  1  SPI chip select, active low
- LCD_SCL  out  1  SPI clock, idles low
- LCD_SDA  out  1  SPI data

## Operation
- ROM entry fields: cmd[7:0], nparam[1:0], params[2][7:0], delay_ms[7:0].
- Init sequence:
  - 11h, 0 params, 120 ms.
  - 3Ah (66h), 0 ms.
  - 36h (00h), 0 ms.
  - B0h (11h, C0h), 0 ms.
  - [21h, 0 params, 0 ms — macro only].
  - 29h, 0 params, 20 ms.
- Sleep sequence:
  - 28h, 0 params, 0 ms.
  - 10h, 0 params, 5 ms.
- States:
  - IDLE
  - RST_LOW
  - RST_WAIT
  - LOAD
  - SHIFT
  - GAP
  - DELAY
  - READY
  - ASLEEP
- Transitions:
  - start in IDLE, READY or ASLEEP → RST_LOW.
  - RST_LOW → RST_WAIT → LOAD at the init index.
  - LOAD → SHIFT for the cmd byte, then one SHIFT per param.
  - GAP follows every byte.
  - After the last byte of an entry: DELAY if delay_ms≠0, otherwise LOAD of the next entry.
  - After the last init entry → READY; after the last sleep entry → ASLEEP.
- sleep_req in READY:
  - Clear panel_ready in the same cycle, then → LOAD at the sleep index.
  - In IDLE or ASLEEP: ignored.
  - While busy with init: latched, and the sleep sequence is executed immediately after init completes. panel_ready never rises, and no `done` is issued for the init run.
- start while busy: ignored.
- Byte format: 9 bits, D/C first (0 = cmd, 1 = param), then D7..D0 MSB-first.
- Delay counting: a 20-bit ms-tick counter counts to MS_CYC−1, and an 8-bit ms counter counts to delay_ms. All counters saturate and never wrap.

## Timing
- Reset values:
  - LCD_RESETn=0, LCD_CS=1, LCD_SCL=0, LCD_SDA=0.
  - panel_ready=0, busy=0, done=0, state IDLE.
- Reset acts immediately regardless of state, including mid-byte. LCD_RESETn is released only by a subsequent start.
- start at cycle 0:
  - busy=1 and LCD_RESETn=0 from cycle 1 for RESET_LOW_CYC cycles.
  - LCD_RESETn rises, then RESET_WAIT_CYC cycles elapse.
  - LCD_CS then falls with SDA already valid (the D/C bit).
- Bit timing:
  - Each bit is SCL low for CLK_DIV cycles, then high for CLK_DIV cycles. SDA changes only while SCL is low and is sampled on SCL rise.
  - A byte holds CS low for 18·CLK_DIV cycles. SCL returns low on the cycle CS rises.
  - GAP holds CS high for CLK_DIV cycles.
- DELAY lasts delay_ms·MS_CYC cycles, starting after GAP.
- Completion:
  - panel_ready rises in the cycle after the final 29h delay ends.
  - done pulses in that same cycle, and busy falls.
  - Sleep completion gives done=1 and busy=0 with panel_ready staying 0.

## Configuration
- ST7785_INVON_EN defined: the init ROM includes 21h (display inversion on). Init sends 10 SPI bytes across 6 entries.
- Undefined: 21h is omitted. Init sends 9 SPI bytes across 5 entries. The panel keeps its power-on inversion-off default.

## Test plan
All scenarios use CLK_DIV=2, MS_CYC=10, RESET_LOW_CYC=5, RESET_WAIT_CYC=10.
- Reset assertion → all outputs equal their reset values. start with gRst held → no activity.
- start, macro undefined:
  - LCD_RESETn low for 5 cycles, first CS fall 10 cycles after release.
  - Decoded bytes: 0_11, 1200-cycle delay, 0_3A, 1_66, 0_36, 1_00, 0_B0, 1_11, 1_C0, 0_29, 200-cycle delay.
  - Then panel_ready=1 with a single-cycle done.
- start with ST7785_INVON_EN defined → 0_21 appears between 1_C0 and 0_29; 10 bytes in total.
- sleep_req in READY → panel_ready=0 next cycle; bytes 0_28 then 0_10; 50-cycle delay; done=1; state ASLEEP. A second sleep_req is ignored.
- sleep_req during the init delay → init finishes, then 0_28 and 0_10 are sent, panel_ready never rises, and done pulses once.
- gRst asserted mid-byte (CS low) → CS=1, SCL=0, LCD_RESETn=0 immediately. A following start re-runs the full sequence from RST_LOW.
